// File: rtl/mux_behavioral_pkg.sv
// Shared select encodings for the four-input multiplexer and its consumers.
package mux_behavioral_pkg;

    typedef enum logic [1:0] {
        SEL_I0 = 2'b00,
        SEL_I1 = 2'b01,
        SEL_I2 = 2'b10,
        SEL_I3 = 2'b11
    } sel_e;

endpackage

// File: rtl/mux4_comb.sv
// Purely combinational 4:1 select of i0..i3 onto d by {s1,s0}.
module mux4_comb
    import mux_behavioral_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] d
);

    sel_e sel;

    assign sel = sel_e'({s1, s0});

    // An unknown select propagates as X rather than falling back to an input.
    always_comb begin
        d = 'x;
        case (sel)
            SEL_I0:  d = i0;
            SEL_I1:  d = i1;
            SEL_I2:  d = i2;
            SEL_I3:  d = i3;
            default: d = 'x;
        endcase
    end

endmodule

// File: rtl/mux_behavioral.sv
// 4:1 multiplexer with a registered copy of the output, select and a change strobe.
module mux_behavioral
    import mux_behavioral_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] d_q,
    output logic [1:0]       sel_q,
    output logic             d_chg
);

    mux4_comb #(
        .WIDTH(WIDTH)
    ) u_mux4_comb (
        .i0(i0),
        .i1(i1),
        .i2(i2),
        .i3(i3),
        .s0(s0),
        .s1(s1),
        .d (d)
    );

    // d_chg compares against the pre-edge d_q, so the first sample after reset compares against 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q   <= '0;
            sel_q <= SEL_I0;
            d_chg <= 1'b0;
        end else begin
            d_q   <= d;
            sel_q <= {s1, s0};
            d_chg <= (d != d_q);
        end
    end

endmodule

// File: tb/tb_mux_behavioral.sv
// Directed bench for mux_behavioral: combinational select at WIDTH=1 and 8, plus the register stage.
module tb_mux_behavioral;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s0 = 1'b0;
    logic       s1 = 1'b0;
    logic [0:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0;
    logic [0:0] d, d_q;
    logic [1:0] sel_q;
    logic       d_chg;

    logic [7:0] w_i0 = '0, w_i1 = '0, w_i2 = '0, w_i3 = '0;
    logic [7:0] w_d, w_d_q;
    logic [1:0] w_sel_q;
    logic       w_d_chg;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    mux_behavioral #(.WIDTH(1)) u_dut (
        .clk(clk), .rst(rst),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .s0(s0), .s1(s1),
        .d(d), .d_q(d_q), .sel_q(sel_q), .d_chg(d_chg)
    );

    mux_behavioral #(.WIDTH(8)) u_dut_w8 (
        .clk(clk), .rst(rst),
        .i0(w_i0), .i1(w_i1), .i2(w_i2), .i3(w_i3),
        .s0(s0), .s1(s1),
        .d(w_d), .d_q(w_d_q), .sel_q(w_sel_q), .d_chg(w_d_chg)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive1(input logic [3:0] ins, input logic [1:0] sel);
        i0 = ins[0];
        i1 = ins[1];
        i2 = ins[2];
        i3 = ins[3];
        {s1, s0} = sel;
    endtask

    initial begin
        // reset held for two edges
        drive1(4'b0000, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_d_q",   {7'd0, d_q},   8'h00);
        check("rst_sel_q", {6'd0, sel_q}, 8'h00);
        check("rst_d_chg", {7'd0, d_chg}, 8'h00);

        // all-zero data, sweep select
        for (int s = 0; s < 4; s++) begin
            drive1(4'b0000, 2'(s));
            #50;
            check($sformatf("zero_sel%0d", s), {7'd0, d}, 8'h00);
        end

        // one-hot data matching the select
        for (int s = 0; s < 4; s++) begin
            drive1(4'b0001 << s, 2'(s));
            #50;
            check($sformatf("match_sel%0d", s), {7'd0, d}, 8'h01);
        end

        // one-hot data on an unselected input
        drive1(4'b1000, 2'b00); #50; check("miss_i3_sel0", {7'd0, d}, 8'h00);
        drive1(4'b0001, 2'b11); #50; check("miss_i0_sel3", {7'd0, d}, 8'h00);
        drive1(4'b1110, 2'b00); #50; check("miss_rest_sel0", {7'd0, d}, 8'h00);
        drive1(4'b0111, 2'b11); #50; check("miss_rest_sel3", {7'd0, d}, 8'h00);

        // WIDTH=8 sweep
        w_i0 = 8'h11; w_i1 = 8'h22; w_i2 = 8'h44; w_i3 = 8'h88;
        {s1, s0} = 2'b00; #50; check("w8_sel0", w_d, 8'h11);
        {s1, s0} = 2'b01; #50; check("w8_sel1", w_d, 8'h22);
        {s1, s0} = 2'b10; #50; check("w8_sel2", w_d, 8'h44);
        {s1, s0} = 2'b11; #50; check("w8_sel3", w_d, 8'h88);

        // register path: i2=1, sel=10, still in reset
        @(negedge clk);
        drive1(4'b0100, 2'b10);
        @(posedge clk); #1;
        check("hold_rst_d_q", {7'd0, d_q}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reg_d_q",   {7'd0, d_q},   8'h01);
        check("reg_sel_q", {6'd0, sel_q}, 8'h02);
        check("reg_d_chg", {7'd0, d_chg}, 8'h01);
        check("w8_reg_d_q", w_d_q, 8'h44);
        @(posedge clk); #1;
        check("held_d_q",   {7'd0, d_q},   8'h01);
        check("held_d_chg", {7'd0, d_chg}, 8'h00);

        // mid-stream reset for one cycle
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_d_q",   {7'd0, d_q},   8'h00);
        check("mid_rst_sel_q", {6'd0, sel_q}, 8'h00);
        check("mid_rst_d_chg", {7'd0, d_chg}, 8'h00);
        check("mid_rst_d",     {7'd0, d},     8'h01);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_d_q",   {7'd0, d_q},   8'h01);
        check("post_rst_d_chg", {7'd0, d_chg}, 8'h01);

        // select and data change together: i1=1, sel=01 -> same value, no strobe
        @(negedge clk);
        drive1(4'b0010, 2'b01);
        @(posedge clk); #1;
        check("same_edge_d_q",   {7'd0, d_q},   8'h01);
        check("same_edge_sel_q", {6'd0, sel_q}, 8'h01);
        check("same_edge_d_chg", {7'd0, d_chg}, 8'h00);
        check("w8_same_edge_d_q",   w_d_q,   8'h22);
        check("w8_same_edge_d_chg", {7'd0, w_d_chg}, 8'h01);

        // falling value: sel=00 with i0=0
        @(negedge clk);
        drive1(4'b0010, 2'b00);
        @(posedge clk); #1;
        check("fall_d_q",   {7'd0, d_q},   8'h00);
        check("fall_sel_q", {6'd0, sel_q}, 8'h00);
        check("fall_d_chg", {7'd0, d_chg}, 8'h01);
        @(posedge clk); #1;
        check("fall_hold_d_chg", {7'd0, d_chg}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
